// File: rtl/seven_seg_ctrl.sv
// Multiplexed common-anode 7-segment display controller.
// A converter FSM captures VALUE/MODE whenever they change and, for decimal
// mode, runs a one-shift-per-cycle double-dabble conversion. The result is
// committed to a display register in a single edge so all digits update
// together. A free-running scanner walks the digits, applies leading-zero
// blanking, decimal points and PWM brightness live, and registers the pins.
module seven_seg_ctrl #(
  parameter int CLK_FREQ = 100000000,
  parameter int DIGIT_HZ = 1000,
  parameter int DIGITS   = 8,
  parameter int BRIGHT_W = 4
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic                  MODE,
  input  logic                  BLANK_LZ,
  input  logic [DIGITS-1:0]     DP,
  input  logic [BRIGHT_W-1:0]   BRIGHT,
  output logic [7:0]            CATHODE,
  output logic [DIGITS-1:0]     ANODE,
  output logic                  BUSY,
  output logic                  OVF
);

  localparam int VALUE_W     = 4 * DIGITS;
  localparam int DIGIT_TICKS = CLK_FREQ / DIGIT_HZ;
  localparam int BCD_DIGITS  = DIGITS + (DIGITS + 3) / 4;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int TICK_W      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W       = $clog2(VALUE_W + 1);
  localparam int PWM_DIV     = DIGIT_TICKS >> BRIGHT_W;

  // Converter states. state is kept as a named signal so checkers can bind to it.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]          state;
  logic                first_conv;
  logic [VALUE_W-1:0]  cap_value;
  logic                cap_mode;
  logic [VALUE_W-1:0]  bin;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    shift_cnt;
  logic                dec_ovf;

  logic [VALUE_W-1:0]  disp;
  logic                disp_ovf;
  logic                ovf_q;

  logic [TICK_W-1:0]   tick;
  logic [IDX_W-1:0]    digit;
  logic [BRIGHT_W-1:0] pwm_cnt;

  logic [DIGITS-1:0]   lz_zero;
  logic                lz_run;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                cur_dp;
  logic [6:0]          cur_seg;
  logic                anode_on;

  // Segment patterns in gfedcba order.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h67;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit above 4 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                      bcd_adj[4*i +: 4] = bcd[4*i +: 4];
    end
  end

  // Any nonzero digit above the displayable range means the value does not fit.
  assign dec_ovf = |bcd[BCD_W-1:VALUE_W];

  // Converter FSM: capture on change, convert (decimal only), commit atomically.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= S_IDLE;
      first_conv <= 1'b1;
      cap_value  <= '0;
      cap_mode   <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      shift_cnt  <= '0;
      disp       <= '0;
      disp_ovf   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (first_conv || (VALUE != cap_value) || (MODE != cap_mode)) begin
            first_conv <= 1'b0;
            cap_value  <= VALUE;
            cap_mode   <= MODE;
            bin        <= VALUE;
            bcd        <= '0;
            shift_cnt  <= '0;
            state      <= MODE ? S_CONV : S_COMMIT;
          end
        end
        S_CONV: begin
          bcd       <= {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
          bin       <= {bin[VALUE_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + CNT_W'(1);
          if (shift_cnt == CNT_W'(VALUE_W - 1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (cap_mode) begin
            disp     <= bcd[VALUE_W-1:0];
            disp_ovf <= dec_ovf;
            ovf_q    <= dec_ovf;
          end else begin
            disp     <= cap_value;
            disp_ovf <= 1'b0;
            ovf_q    <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);
  assign OVF  = ovf_q;

  // Scan timebase: tick counter per digit slot, digit index advances on wrap.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      tick  <= '0;
      digit <= '0;
    end else if (tick == TICK_W'(DIGIT_TICKS - 1)) begin
      tick  <= '0;
      digit <= (digit == IDX_W'(DIGITS - 1)) ? '0 : digit + IDX_W'(1);
    end else begin
      tick <= tick + TICK_W'(1);
    end
  end

  assign pwm_cnt  = BRIGHT_W'(tick / TICK_W'(PWM_DIV));
  assign anode_on = (&BRIGHT) || (pwm_cnt < BRIGHT);

  // Leading-zero map: lz_zero[i] is set when digit i and everything above it are 0.
  always_comb begin
    lz_zero = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run && (disp[4*i +: 4] == 4'd0);
      lz_zero[i] = lz_run;
    end
  end

  // Select the active digit's nibble, blanking state and decimal point.
  always_comb begin
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit == IDX_W'(i)) begin
        cur_nib   = disp[4*i +: 4];
        cur_blank = lz_zero[i] && (i != 0);
        cur_dp    = DP[i];
      end
    end
  end

  // Overflow dashes take priority and are never blanked.
  always_comb begin
    if (disp_ovf)                    cur_seg = 7'h40;
    else if (BLANK_LZ && cur_blank)  cur_seg = 7'h00;
    else                             cur_seg = glyph(cur_nib);
  end

  // Registered pin drivers, active-low; at most one anode low at a time.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      CATHODE <= 8'hFF;
      ANODE   <= '1;
    end else begin
      CATHODE <= ~{cur_dp, cur_seg};
      ANODE   <= anode_on ? ~(DIGITS'(1) << digit) : '1;
    end
  end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Directed bench for seven_seg_ctrl: 8 digits, 16 ticks per digit slot.
module tb_seven_seg_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] value = '0;
  logic        mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  dp = '0;
  logic [3:0]  bright = 4'hF;
  logic [7:0]  cathode;
  logic [7:0]  anode;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h67, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] exp_cat [8];

  seven_seg_ctrl #(
    .CLK_FREQ(1600),
    .DIGIT_HZ(100),
    .DIGITS  (8),
    .BRIGHT_W(4)
  ) dut (
    .CLK     (clk),
    .RESETN  (resetn),
    .VALUE   (value),
    .MODE    (mode),
    .BLANK_LZ(blank_lz),
    .DP      (dp),
    .BRIGHT  (bright),
    .CATHODE (cathode),
    .ANODE   (anode),
    .BUSY    (busy),
    .OVF     (ovf)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Advance n edges, landing 1 time unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected cathodes from a hand-written digit string (digit 0 in the low nibble).
  task automatic set_exp(input logic [31:0] nibs);
    logic [3:0] n;
    for (int i = 0; i < 8; i++) begin
      n = nibs[4*i +: 4];
      exp_cat[i] = ~glyph[n];
    end
  endtask

  // Wait for a triggered conversion to finish and check the BUSY duration.
  task automatic wait_commit(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    cyc(1);
    while (busy && cnt < 200) begin
      cnt++;
      cyc(1);
    end
    n_checks++;
    if (cnt !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cnt, exp_cycles);
    end
  endtask

  // Observe a full scan frame and compare each digit's cathode with exp_cat.
  task automatic scan_check(input string name);
    logic       seen [8];
    logic       bad  [8];
    logic [7:0] got  [8];
    logic       multi;
    int         z;
    int         idx;
    multi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen[i] = 1'b0;
      bad[i]  = 1'b0;
      got[i]  = 8'h00;
    end
    cyc(2);
    for (int c = 0; c < 144; c++) begin
      cyc(1);
      z = 0;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
        if (anode[i] === 1'b0) begin
          z++;
          idx = i;
        end
      end
      if (z > 1) multi = 1'b1;
      else if (z == 1) begin
        if (!seen[idx]) begin
          seen[idx] = 1'b1;
          got[idx]  = cathode;
        end else if (cathode !== got[idx]) begin
          bad[idx] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (!seen[i] || bad[i] || got[i] !== exp_cat[i]) begin
        n_fail++;
        $display("FAIL %s_digit%0d: got %02h (seen=%0b unstable=%0b) expected %02h",
                 name, i, got[i], seen[i], bad[i], exp_cat[i]);
      end
    end
    n_checks++;
    if (multi !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_one_anode: got multiple low anodes expected at most one", name);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cyc(3);
    n_checks++;
    if (cathode !== 8'hFF) begin n_fail++; $display("FAIL reset_cathode: got %02h expected ff", cathode); end
    n_checks++;
    if (anode !== 8'hFF) begin n_fail++; $display("FAIL reset_anode: got %02h expected ff", anode); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    resetn = 1'b1;
    cyc(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_conv: got busy %b expected 1", busy); end
    cyc(1);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_first_done: got busy %b expected 0", busy); end
  endtask

  task automatic test_hex;
    logic [7:0] prev;
    logic       started;
    int         run;
    int         made;
    mode  = 1'b0;
    value = 32'h12AB_00F5;
    wait_commit("hex", 1);
    set_exp(32'h12AB_00F5);
    scan_check("hex");
    // Slot order and slot length.
    prev = anode;
    started = 1'b0;
    run = 0;
    made = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1);
      if (anode !== prev) begin
        if (started) begin
          made++;
          n_checks++;
          if (run !== 16 || anode !== {prev[6:0], prev[7]}) begin
            n_fail++;
            $display("FAIL hex_scan_order: got %02h after %0d cycles expected %02h after 16",
                     anode, run, {prev[6:0], prev[7]});
          end
        end
        started = 1'b1;
        run = 1;
        prev = anode;
      end else begin
        run++;
      end
    end
    n_checks++;
    if (made < 3) begin n_fail++; $display("FAIL hex_scan_steps: got %0d expected at least 3", made); end
  endtask

  task automatic test_decimal;
    mode  = 1'b1;
    value = 32'd12345678;
    wait_commit("dec", 33);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL dec_ovf: got %b expected 0", ovf); end
    set_exp(32'h1234_5678);
    scan_check("dec");
  endtask

  task automatic test_overflow;
    mode  = 1'b1;
    value = 32'hFFFF_FFFF;
    wait_commit("ovf", 33);
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    for (int i = 0; i < 8; i++) exp_cat[i] = 8'hBF;
    scan_check("ovf");
    value = 32'd7;
    wait_commit("ovf_clear", 33);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_blank;
    mode     = 1'b1;
    blank_lz = 1'b1;
    dp       = 8'h04;
    value    = 32'd42;
    wait_commit("blank", 33);
    exp_cat[0] = 8'hA4;
    exp_cat[1] = 8'h99;
    exp_cat[2] = 8'h7F;
    for (int i = 3; i < 8; i++) exp_cat[i] = 8'hFF;
    scan_check("blank");
    blank_lz = 1'b0;
    dp       = 8'h00;
  endtask

  task automatic test_bright;
    int low [8];
    int lit;
    bright = 4'd4;
    cyc(2);
    for (int i = 0; i < 8; i++) low[i] = 0;
    for (int c = 0; c < 128; c++) begin
      cyc(1);
      for (int i = 0; i < 8; i++) if (anode[i] === 1'b0) low[i]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (low[i] !== 4) begin
        n_fail++;
        $display("FAIL bright4_digit%0d: got %0d low cycles expected 4", i, low[i]);
      end
    end
    bright = 4'd0;
    cyc(2);
    lit = 0;
    for (int c = 0; c < 128; c++) begin
      cyc(1);
      if (anode !== 8'hFF) lit++;
    end
    n_checks++;
    if (lit !== 0) begin n_fail++; $display("FAIL bright0_dark: got %0d lit cycles expected 0", lit); end
    bright = 4'hF;
    cyc(2);
  endtask

  task automatic test_back_to_back;
    int cnt;
    int idx;
    mode  = 1'b1;
    value = 32'd11111111;
    cyc(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL race_start: got busy %b expected 1", busy); end
    cyc(10);
    value = 32'd22222222;
    cnt = 0;
    while (busy && cnt < 200) begin cnt++; cyc(1); end
    n_checks++;
    if (cnt !== 23) begin n_fail++; $display("FAIL race_first_len: got %0d expected 23", cnt); end
    cyc(1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL race_restart: got busy %b expected 1", busy); end
    cyc(4);
    idx = -1;
    for (int i = 0; i < 8; i++) if (anode[i] === 1'b0) idx = i;
    n_checks++;
    if (idx < 0 || cathode !== 8'hF9) begin
      n_fail++;
      $display("FAIL race_first_commit: got %02h on digit %0d expected f9", cathode, idx);
    end
    cnt = 0;
    while (busy && cnt < 200) begin cnt++; cyc(1); end
    n_checks++;
    if (cnt >= 200) begin n_fail++; $display("FAIL race_second_done: got timeout expected completion"); end
    set_exp(32'h2222_2222);
    scan_check("race_final");
  endtask

  task automatic test_reset_mid;
    mode  = 1'b1;
    value = 32'hFFFF_FFFF;
    wait_commit("rst_pre", 33);
    value = 32'd5;
    cyc(6);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_in_conv: got busy %b expected 1", busy); end
    resetn = 1'b0;
    cyc(1);
    n_checks++;
    if (cathode !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_cathode: got %02h expected ff", cathode); end
    n_checks++;
    if (anode !== 8'hFF) begin n_fail++; $display("FAIL rst_mid_anode: got %02h expected ff", anode); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b expected 0", ovf); end
    cyc(2);
    resetn = 1'b1;
    wait_commit("rst_post", 33);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_post_ovf: got %b expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_blank();
    test_bright();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
